// File: rtl/z32_mem_bus_unit_if.sv
// Valid/ready SoC bus seen by the Z32 memory-access unit.
// The unit drives the request side; the fabric answers with ready/err/rdata.
interface z32_mem_bus_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  bus_valid;
  logic                  bus_we;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic [DATA_W/8-1:0]   bus_be;
  logic                  bus_ready;
  logic                  bus_err;
  logic [DATA_W-1:0]     bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ready, bus_err, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ready, bus_err, bus_rdata
  );
endinterface

// File: rtl/z32_mem_bus_unit.sv
// Z32 memory-access unit: owns MAR/MDR and runs one sized, lane-aligned
// bus transaction at a time, with alignment check, bus-error capture and timeout.
//   state  | meaning
//   S_IDLE | accepting MAR/MDR loads and starts
//   S_BUS  | request on the bus, waiting for ready or timeout
//   S_RESP | one-cycle done pulse
module z32_mem_bus_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mar_we,
  input  logic [ADDR_W-1:0]   mar_din,
  input  logic                mdr_we,
  input  logic [DATA_W-1:0]   mdr_din,
  input  logic [1:0]          size,
  input  logic                rd_start,
  input  logic                wr_start,
  input  logic                fault_clr,
  output logic [ADDR_W-1:0]   mar,
  output logic [DATA_W-1:0]   mdr,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic [1:0]          fault_cause,
  z32_mem_bus_unit_if.master  mem_bus
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_TC = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic              op_we;
  logic [1:0]        op_size;
  logic [LB-1:0]     lane_off;
  logic [CW-1:0]     cnt;

  logic              start_one, start_both, size_legal, aligned, timeout_hit;
  logic [2:0]        align_mask;
  logic              fault_set;
  logic [1:0]        fault_code;
  logic [NB-1:0]     be_base;
  logic [DATA_W-1:0] wdata_rep, rd_shift, rd_sel;

  assign start_one   = rd_start ^ wr_start;
  assign start_both  = rd_start & wr_start;
  assign size_legal  = (size != 2'd3) || (DATA_W == 64);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_TC);
  assign rd_shift    = mem_bus.bus_rdata >> {lane_off, 3'b000};

  always_comb begin
    align_mask = 3'd0;
    case (size)
      2'd1:    align_mask = 3'd1;
      2'd2:    align_mask = 3'd3;
      2'd3:    align_mask = 3'd7;
      default: align_mask = 3'd0;
    endcase
    aligned = size_legal && ((mar[LB-1:0] & align_mask[LB-1:0]) == '0);
  end

  // Lane shaping: byte mask, replicated write data and zero-extended read data.
  always_comb begin
    be_base   = '0;
    wdata_rep = '0;
    rd_sel    = '0;
    for (int i = 0; i < NB; i++) begin
      be_base[i]          = (i < (1 << op_size));
      wdata_rep[8*i +: 8] = mdr[8*(i & ((1 << op_size) - 1)) +: 8];
      rd_sel[8*i +: 8]    = (i < (1 << op_size)) ? rd_shift[8*i +: 8] : 8'h00;
    end
  end

  always_comb begin
    fault_set  = 1'b0;
    fault_code = 2'd0;
    case (state)
      S_IDLE: begin
        if (start_both) begin
          fault_set  = 1'b1;
          fault_code = 2'd3;
        end else if (start_one && !aligned) begin
          fault_set  = 1'b1;
          fault_code = 2'd1;
        end
      end
      S_BUS: begin
        if (mem_bus.bus_ready && mem_bus.bus_err) begin
          fault_set  = 1'b1;
          fault_code = 2'd3;
        end else if (!mem_bus.bus_ready && timeout_hit) begin
          fault_set  = 1'b1;
          fault_code = 2'd2;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mar         <= '0;
      mdr         <= '0;
      op_we       <= 1'b0;
      op_size     <= 2'd0;
      lane_off    <= '0;
      cnt         <= '0;
      fault       <= 1'b0;
      fault_cause <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mar_we) mar <= mar_din;
          if (mdr_we) mdr <= mdr_din;
          if (start_both || (start_one && !aligned)) begin
            state <= S_RESP;
          end else if (start_one) begin
            state    <= S_BUS;
            op_we    <= wr_start;
            op_size  <= size;
            lane_off <= mar[LB-1:0];
            cnt      <= '0;
          end
        end
        S_BUS: begin
          if (mem_bus.bus_ready) begin
            if (!op_we && !mem_bus.bus_err) mdr <= rd_sel;
            state <= S_RESP;
          end else if (timeout_hit) begin
            state <= S_RESP;
          end else if (TIMEOUT != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // A fault raised in the same cycle as fault_clr takes precedence.
      if (fault_set) begin
        fault       <= 1'b1;
        fault_cause <= fault_code;
      end else if (fault_clr) begin
        fault       <= 1'b0;
        fault_cause <= 2'd0;
      end
    end
  end

  assign busy              = (state != S_IDLE);
  assign done              = (state == S_RESP);
  assign mem_bus.bus_valid = (state == S_BUS);
  assign mem_bus.bus_we    = (state == S_BUS) && op_we;
  assign mem_bus.bus_addr  = {mar[ADDR_W-1:LB], {LB{1'b0}}};
  assign mem_bus.bus_be    = (state == S_BUS) ? (be_base << lane_off) : '0;
  assign mem_bus.bus_wdata = ((state == S_BUS) && op_we) ? wdata_rep : '0;
endmodule

// File: tb/tb_z32_mem_bus_unit.sv
// Bench for z32_mem_bus_unit (DATA_W=32, TIMEOUT=4): directed vector table,
// hand-written multi-cycle corner cases and random transactions vs an arithmetic model.
module tb_z32_mem_bus_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mar_we = 1'b0, mdr_we = 1'b0;
  logic [31:0] mar_din = '0, mdr_din = '0;
  logic [1:0]  size = '0;
  logic        rd_start = 1'b0, wr_start = 1'b0, fault_clr = 1'b0;
  logic [31:0] mar, mdr;
  logic        busy, done, fault;
  logic [1:0]  fault_cause;
  int          n_cmp = 0;
  int          n_bad = 0;

  z32_mem_bus_unit_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  z32_mem_bus_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mar_we(mar_we), .mar_din(mar_din), .mdr_we(mdr_we), .mdr_din(mdr_din),
    .size(size), .rd_start(rd_start), .wr_start(wr_start), .fault_clr(fault_clr),
    .mar(mar), .mdr(mdr), .busy(busy), .done(done),
    .fault(fault), .fault_cause(fault_cause),
    .mem_bus(bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mar_v;
    logic [31:0] mdr_v;
    logic [1:0]  sz;
    logic        wr;
    logic [31:0] rdata;
    int          delay;
    logic        err;
    logic [31:0] exp_mdr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_addr;
    logic [1:0]  exp_cause;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model straight from the access rules, using plain arithmetic.
  function automatic vec_t model(input logic [31:0] m, input logic [31:0] d, input logic [1:0] sz,
                                 input logic wr, input logic [31:0] rd, input int dly, input logic e);
    vec_t v;
    longint unsigned nb, off, span, rep;
    nb   = 64'(1) << sz;
    off  = 64'(m) % 4;
    span = 64'(1) << (8 * nb);
    rep  = (nb == 1) ? 64'h0101_0101 : (nb == 2) ? 64'h0001_0001 : 64'h1;
    v.mar_v = m; v.mdr_v = d; v.sz = sz; v.wr = wr; v.rdata = rd; v.delay = dly; v.err = e;
    v.exp_addr  = m - 32'(off);
    v.exp_be    = 4'(((64'(1) << nb) - 1) << off);
    v.exp_wdata = 32'((64'(d) % span) * rep);
    v.exp_mdr   = (wr || e) ? d : 32'((64'(rd) >> (8 * off)) % span);
    if (sz == 2'd3 || (64'(m) % nb) != 0) v.exp_cause = 2'd1;
    else if (e)                           v.exp_cause = 2'd3;
    else                                  v.exp_cause = 2'd0;
    return v;
  endfunction

  task automatic load(input logic [31:0] m, input logic [31:0] d);
    mar_we = 1'b1; mar_din = m; mdr_we = 1'b1; mdr_din = d; fault_clr = 1'b1;
    tick();
    mar_we = 1'b0; mdr_we = 1'b0; fault_clr = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string name);
    load(v.mar_v, v.mdr_v);
    size = v.sz; rd_start = !v.wr; wr_start = v.wr;
    tick();
    rd_start = 1'b0; wr_start = 1'b0;
    if (v.exp_cause == 2'd1) begin
      check({name, ".ill_valid"}, 64'(bus_if.bus_valid), 64'd0);
      check({name, ".ill_done"},  64'(done), 64'd1);
      check({name, ".ill_fault"}, 64'(fault), 64'd1);
      check({name, ".ill_cause"}, 64'(fault_cause), 64'd1);
      tick();
      check({name, ".ill_idle"},  64'({done, busy}), 64'd0);
      return;
    end
    check({name, ".valid"}, 64'(bus_if.bus_valid), 64'd1);
    check({name, ".early_done"}, 64'(done), 64'd0);
    check({name, ".addr"},  64'(bus_if.bus_addr), 64'(v.exp_addr));
    check({name, ".be"},    64'(bus_if.bus_be), 64'(v.exp_be));
    check({name, ".we"},    64'(bus_if.bus_we), 64'(v.wr));
    if (v.wr) check({name, ".wdata"}, 64'(bus_if.bus_wdata), 64'(v.exp_wdata));
    for (int k = 0; k < v.delay; k++) begin
      tick();
      check({name, ".wait_valid"}, 64'(bus_if.bus_valid), 64'd1);
    end
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = v.rdata; bus_if.bus_err = v.err;
    tick();
    bus_if.bus_ready = 1'b0; bus_if.bus_err = 1'b0;
    check({name, ".done"},  64'({done, busy, bus_if.bus_valid}), 64'b110);
    check({name, ".mdr"},   64'(mdr), 64'(v.exp_mdr));
    check({name, ".fault"}, 64'(fault), 64'(v.exp_cause != 2'd0));
    if (v.exp_cause != 2'd0) check({name, ".cause"}, 64'(fault_cause), 64'(v.exp_cause));
    tick();
    check({name, ".idle"}, 64'({done, busy}), 64'd0);
  endtask

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    vec_t r;
    logic [31:0] rm;
    logic [1:0]  rs;

    //           mar           mdr           sz  wr   rdata        dly err  exp_mdr       be     wdata         addr          cause
    tbl[0] = '{32'h0000_1000, 32'h0,        2, 1'b0, 32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 4'hF, 32'h0,        32'h0000_1000, 2'd0};
    tbl[1] = '{32'h0000_1003, 32'h0,        0, 1'b0, 32'hAABBCCDD, 0, 1'b0, 32'h0000_00AA, 4'h8, 32'h0,        32'h0000_1000, 2'd0};
    tbl[2] = '{32'h0000_2002, 32'h0000_1234, 1, 1'b1, 32'h0,       0, 1'b0, 32'h0000_1234, 4'hC, 32'h1234_1234, 32'h0000_2000, 2'd0};
    tbl[3] = '{32'h0000_1001, 32'h0,        2, 1'b0, 32'h0,        0, 1'b0, 32'h0,        4'h0, 32'h0,        32'h0,        2'd1};
    tbl[4] = '{32'h0000_1000, 32'h0,        3, 1'b0, 32'h0,        0, 1'b0, 32'h0,        4'h0, 32'h0,        32'h0,        2'd1};
    tbl[5] = '{32'h0000_3005, 32'h0000_005A, 0, 1'b1, 32'h0,       2, 1'b0, 32'h0000_005A, 4'h2, 32'h5A5A_5A5A, 32'h0000_3004, 2'd0};
    tbl[6] = '{32'h0000_4000, 32'h0,        1, 1'b0, 32'h1234ABCD, 1, 1'b0, 32'h0000_ABCD, 4'h3, 32'h0,        32'h0000_4000, 2'd0};
    tbl[7] = '{32'h0000_5000, 32'h0000_0077, 2, 1'b0, 32'hFFFFFFFF, 0, 1'b1, 32'h0000_0077, 4'hF, 32'h0,        32'h0000_5000, 2'd3};
    tbl[8] = '{32'h0000_6003, 32'h0,        1, 1'b0, 32'h0,        0, 1'b0, 32'h0,        4'h0, 32'h0,        32'h0,        2'd1};
    tbl[9] = '{32'h0000_7004, 32'hCAFEF00D, 2, 1'b1, 32'h0,        3, 1'b0, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 32'h0000_7004, 2'd0};

    bus_if.bus_ready = 1'b0; bus_if.bus_err = 1'b0; bus_if.bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.state", 64'({busy, done, fault, fault_cause, bus_if.bus_valid, bus_if.bus_we}), 64'd0);
    check("rst.regs",  64'({mar, mdr}), 64'd0);
    check("rst.bus",   64'({bus_if.bus_be, bus_if.bus_wdata}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // fault_clr clears a held fault
    run_txn(tbl[3], "clr_setup");
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("clr.fault", 64'(fault), 64'd0);

    // new fault beats fault_clr in the same cycle
    run_txn(tbl[3], "race_setup");
    size = 2'd2; rd_start = 1'b1; fault_clr = 1'b1;
    tick();
    rd_start = 1'b0; fault_clr = 1'b0;
    check("race.fault", 64'({fault, fault_cause}), 64'b101);
    tick();

    // simultaneous read and write start
    load(32'h0000_1000, 32'h0);
    rd_start = 1'b1; wr_start = 1'b1; tick(); rd_start = 1'b0; wr_start = 1'b0;
    check("conflict.done",  64'({done, bus_if.bus_valid}), 64'b10);
    check("conflict.cause", 64'({fault, fault_cause}), 64'b111);
    tick();

    // timeout, with MAR writes attempted while busy
    load(32'h0000_1000, 32'h0);
    size = 2'd2; rd_start = 1'b1; tick(); rd_start = 1'b0;
    mar_we = 1'b1; mar_din = 32'h0000_FFFF;
    n = 0;
    while (bus_if.bus_valid && n < 10) begin
      n++;
      tick();
    end
    mar_we = 1'b0;
    check("tmo.valid_cycles", 64'(n), 64'd4);
    check("tmo.done",  64'(done), 64'd1);
    check("tmo.cause", 64'({fault, fault_cause}), 64'b110);
    check("tmo.mar_held", 64'(mar), 64'h1000);
    tick();

    // MAR write in the same cycle as start: start sees the old MAR
    load(32'h0000_2000, 32'h0);
    mar_we = 1'b1; mar_din = 32'h0000_2001; size = 2'd2; rd_start = 1'b1;
    tick();
    mar_we = 1'b0; rd_start = 1'b0;
    check("oldmar.valid", 64'({bus_if.bus_valid, fault}), 64'b10);
    check("oldmar.mar",   64'(mar), 64'h2001);
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'h0BAD_F00D; tick(); bus_if.bus_ready = 1'b0;
    check("oldmar.mdr", 64'(mdr), 64'h0BAD_F00D);
    tick();

    // asynchronous reset in the middle of a bus wait
    load(32'h0000_1000, 32'h0000_0055);
    size = 2'd2; rd_start = 1'b1; tick(); rd_start = 1'b0;
    check("arst.pre_valid", 64'(bus_if.bus_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst.state", 64'({bus_if.bus_valid, busy, done, fault}), 64'd0);
    check("arst.regs",  64'({mar, mdr}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    run_txn(tbl[0], "after_rst");

    for (int i = 0; i < 40; i++) begin
      rm = $urandom;
      rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && rs != 2'd3) rm = rm & ~((32'd1 << rs) - 32'd1);
      r = model(rm, $urandom, rs, 1'($urandom_range(0, 1)), $urandom,
                $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
      run_txn(r, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/z32_mem_bus_unit.md
# z32_mem_bus_unit

Parametrised memory-access unit for the Z32 microcoded core: owns the MAR and MDR, turns microcode read/write strobes into single-outstanding transactions on the SoC valid/ready bus, and returns sized, lane-aligned data to the MDR. It sits between the core datapath and the memory/UART/timer fabric. It adds sub-word sizes, byte enables, alignment checking, bus-error capture and a transaction timeout.

## Interface
- ADDR_W, 32, address width (MAR, bus_addr)
- DATA_W, 32, data width; legal values 32 or 64
- TIMEOUT, 255, max cycles waiting for bus_ready; 0 disables the timeout
- clk  in  1  clock
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low
- mar_we  in  1  load MAR from mar_din
- mar_din  in  ADDR_W  MAR load value
- mdr_we  in  1  load MDR from mdr_din
- mdr_din  in  DATA_W  MDR load value
- size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword (DATA_W=64 only)
- rd_start / wr_start  in  1  start a read/write at MAR with size
- fault_clr  in  1  clear sticky fault
- mar  out  ADDR_W  current MAR
- mdr  out  DATA_W  current MDR
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse (success or fault)
- fault  out  1  sticky fault flag
- fault_cause  out  2  1 misaligned/illegal size, 2 timeout, 3 bus error/conflict
- bus_valid, bus_we  out  1  request valid, write strobe
- bus_addr  out  ADDR_W  MAR with low log2(DATA_W/8) bits cleared
- bus_wdata  out  DATA_W  write data
- bus_be  out  DATA_W/8  byte enables
- bus_ready, bus_err  in  1  handshake accept, error response (valid with ready)
- bus_rdata  in  DATA_W  read data

## Operation
- FSM: IDLE, BUS, RESP. Starts accepted only in IDLE.
- IDLE + one start: check alignment (addr low bits multiple of 2^size; size 3 with DATA_W=32 illegal). Legal -> BUS, latch op and lane offset. Illegal -> RESP with fault_cause 1, no bus_valid.
- rd_start and wr_start together: no transaction, RESP, fault_cause 3.
- BUS: bus_valid=1, bus_we=op; address, wdata, be held stable. On bus_ready: read loads MDR with selected lanes shifted to bit 0, zero-extended; write leaves MDR unchanged; bus_err with ready sets fault_cause 3 (MDR unchanged on read). -> RESP.
- Write data: low 2^size bytes of MDR replicated across all lanes; bus_be has 2^size ones starting at lane offset.
- Timeout: counter cleared on entering BUS, increments each BUS cycle without ready; reaching TIMEOUT drops bus_valid, fault_cause 2, -> RESP.
- RESP: done=1 for one cycle -> IDLE.
- fault set with cause on any fault, held until fault_clr; new fault in same cycle as fault_clr wins. Cause overwritten by latest fault.
- mar_we/mdr_we ignored while busy; accepted in IDLE (same-cycle write and start: start uses old MAR).

## Timing
- Reset: all outputs 0, MAR/MDR 0, state IDLE, counter 0; mid-transaction reset drops bus_valid immediately (async).
- Start at cycle t -> bus_valid high t+1; ready at t+1 -> MDR updated and done high t+2; busy high t+1..t+2.
- Fault without bus access: done at t+1.
- Each wait cycle adds one cycle; minimum back-to-back period 3 cycles.
- busy = state != IDLE; all outputs registered or decoded from state.

## Test plan
- DATA_W=32, MAR=0x1000, word read, ready at first valid cycle, rdata 0xDEADBEEF -> MDR 0xDEADBEEF, done at t+2, be 0xF.
- MAR=0x1003 byte read, rdata 0xAABBCCDD -> bus_addr 0x1000, MDR 0x000000AA.
- MAR=0x2002 half write, MDR 0x00001234 -> bus_wdata 0x12341234, bus_be 0xC, bus_we=1.
- MAR=0x1001 word read -> no bus_valid, done at t+1, fault=1 cause 1; fault_clr -> fault 0.
- TIMEOUT=4, ready never -> bus_valid 4 cycles then low, fault cause 2, done; bus_err case -> cause 3, MDR unchanged.
- rst_n low during BUS wait -> bus_valid, busy, mar, mdr 0 same cycle; next start works normally.
